// File: rtl/off_chip_img_stream_feeder_if.sv
// rtl/off_chip_img_stream_feeder_if.sv - upstream pixel stream and app read port bundle for the feeder
interface off_chip_img_stream_feeder_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
);
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              off_chip_img_img_update_0_read_en;
    logic [DATA_W-1:0] off_chip_img_img_update_0_read [0:0];
    logic [LVL_W-1:0]  level;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              frame_done;
    logic              underflow;
`ifdef FEEDER_CHECKSUM_EN
    logic [DATA_W-1:0] frame_checksum;

    modport master (
        output in_valid, in_data, off_chip_img_img_update_0_read_en,
        input  in_ready, off_chip_img_img_update_0_read, level, col, row,
               frame_done, underflow, frame_checksum
    );
    modport slave (
        input  in_valid, in_data, off_chip_img_img_update_0_read_en,
        output in_ready, off_chip_img_img_update_0_read, level, col, row,
               frame_done, underflow, frame_checksum
    );
`else
    modport master (
        output in_valid, in_data, off_chip_img_img_update_0_read_en,
        input  in_ready, off_chip_img_img_update_0_read, level, col, row,
               frame_done, underflow
    );
    modport slave (
        input  in_valid, in_data, off_chip_img_img_update_0_read_en,
        output in_ready, off_chip_img_img_update_0_read, level, col, row,
               frame_done, underflow
    );
`endif
endinterface

// File: rtl/off_chip_img_stream_feeder.sv
// rtl/off_chip_img_stream_feeder.sv - show-ahead pixel FIFO with raster tracking feeding the sobel app read port
// Optional per-frame checksum output enabled by FEEDER_CHECKSUM_EN.
module off_chip_img_stream_feeder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    off_chip_img_stream_feeder_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic              r_frame_done;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_frame_end;
    logic [DATA_W-1:0] w_head;

    assign w_full      = (r_level == LVL_W'(DEPTH));
    assign w_empty     = (r_level == '0);
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_push      = bus.in_valid && !w_full;
    assign w_pop       = bus.off_chip_img_img_update_0_read_en && !w_empty;
    assign w_col_last  = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last  = (r_row == ROW_W'(IMG_H - 1));
    assign w_frame_end = w_pop && w_col_last && w_row_last;
    assign w_head      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            r_frame_done <= w_frame_end;
            if (bus.off_chip_img_img_update_0_read_en && w_empty) begin
                r_underflow <= 1'b1;
            end
            if (w_pop) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

`ifdef FEEDER_CHECKSUM_EN
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_acc      <= '0;
            r_checksum <= '0;
        end else if (w_frame_end) begin
            r_checksum <= r_acc + w_head;
            r_acc      <= '0;
        end else if (w_pop) begin
            r_acc <= r_acc + w_head;
        end
    end

    assign bus.frame_checksum = r_checksum;
`endif

    assign bus.in_ready                          = !w_full;
    assign bus.off_chip_img_img_update_0_read[0] = w_empty ? '0 : w_head;
    assign bus.level                             = r_level;
    assign bus.col                               = r_col;
    assign bus.row                               = r_row;
    assign bus.frame_done                        = r_frame_done;
    assign bus.underflow                         = r_underflow;
endmodule

// File: tb/tb_off_chip_img_stream_feeder.sv
// tb/tb_off_chip_img_stream_feeder.sv - scoreboard bench for the off-chip image stream feeder
module tb_off_chip_img_stream_feeder;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    off_chip_img_stream_feeder_if #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) bus ();

    off_chip_img_stream_feeder #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] q[$];
    int                m_col;
    int                m_row;
    bit                m_fd;
    bit                m_uf;
    logic [DATA_W-1:0] m_acc;
    logic [DATA_W-1:0] m_cks;
    int                fd_seen;
    int                checks;
    int                failures;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs();
        check_eq("read", 32'(bus.off_chip_img_img_update_0_read[0]),
                 (q.size() > 0) ? 32'(q[0]) : 32'd0);
        check_eq("level", 32'(bus.level), 32'(q.size()));
        check_eq("in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
        check_eq("col", 32'(bus.col), 32'(m_col));
        check_eq("row", 32'(bus.row), 32'(m_row));
        check_eq("frame_done", 32'(bus.frame_done), 32'(m_fd));
        check_eq("underflow", 32'(bus.underflow), 32'(m_uf));
`ifdef FEEDER_CHECKSUM_EN
        check_eq("frame_checksum", 32'(bus.frame_checksum), 32'(m_cks));
`endif
        if (bus.frame_done) fd_seen++;
    endtask

    task automatic clear_model();
        q.delete();
        m_col = 0;
        m_row = 0;
        m_fd  = 1'b0;
        m_uf  = 1'b0;
        m_acc = '0;
        m_cks = '0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.off_chip_img_img_update_0_read_en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_model();
    endtask

    // One clock: compare current outputs, drive inputs, advance the reference model across the edge.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit re);
        bit                push;
        bit                pop;
        logic [DATA_W-1:0] pix;
        compare_outputs();
        bus.in_valid = v;
        bus.in_data  = d;
        bus.off_chip_img_img_update_0_read_en = re;
        push = v && (q.size() != DEPTH);
        pop  = re && (q.size() > 0);
        m_fd = 1'b0;
        if (re && q.size() == 0) m_uf = 1'b1;
        if (pop) begin
            pix = q.pop_front();
            if (m_col == IMG_W - 1 && m_row == IMG_H - 1) begin
                m_fd  = 1'b1;
                m_cks = m_acc + pix;
                m_acc = '0;
            end else begin
                m_acc = m_acc + pix;
            end
            if (m_col == IMG_W - 1) begin
                m_col = 0;
                m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        if (push) q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int saved_col;
        checks   = 0;
        failures = 0;
        fd_seen  = 0;

        do_reset();
        compare_outputs();
        check_eq("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset_level", 32'(bus.level), 32'd0);
        check_eq("reset_read", 32'(bus.off_chip_img_img_update_0_read[0]), 32'd0);

        for (int i = 1; i <= 16; i++) cycle(1'b1, DATA_W'(i), 1'b0);
        check_eq("fill_level", 32'(bus.level), 32'd16);
        check_eq("fill_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 16'h0011, 1'b0);
        check_eq("refused_level", 32'(bus.level), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            check_eq("drain_order", 32'(bus.off_chip_img_img_update_0_read[0]), 32'(i));
            cycle(1'b0, '0, 1'b1);
        end
        check_eq("drain_level", 32'(bus.level), 32'd0);

        saved_col = m_col;
        cycle(1'b1, 16'hABCD, 1'b1);
        check_eq("uf_flag", 32'(bus.underflow), 32'd1);
        check_eq("uf_level", 32'(bus.level), 32'd1);
        check_eq("uf_read", 32'(bus.off_chip_img_img_update_0_read[0]), 32'hABCD);
        check_eq("uf_col", 32'(bus.col), 32'(saved_col));
        cycle(1'b0, '0, 1'b1);

        do_reset();
        fd_seen = 0;
        cycle(1'b1, 16'h0001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_eq("wrap_col", 32'(bus.col), 32'(i % IMG_W));
            check_eq("wrap_row", 32'(bus.row), 32'(i / IMG_W));
            cycle(i < 7, DATA_W'(i + 2), 1'b1);
        end
        check_eq("wrap_fd_pulse", 32'(bus.frame_done), 32'd1);
        check_eq("wrap_row_back", 32'(bus.row), 32'd0);
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check_eq("wrap_fd_count", 32'(fd_seen), 32'd1);

        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, DATA_W'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            check_eq("steady_head", 32'(bus.off_chip_img_img_update_0_read[0]), 32'(16'h0100 + i));
            cycle(1'b1, DATA_W'(16'h0108 + i), 1'b1);
        end
        check_eq("steady_level", 32'(bus.level), 32'd8);
        do_reset();
        check_eq("midrst_level", 32'(bus.level), 32'd0);
        check_eq("midrst_read", 32'(bus.off_chip_img_img_update_0_read[0]), 32'd0);
        compare_outputs();

`ifdef FEEDER_CHECKSUM_EN
        cycle(1'b1, 16'hFFFF, 1'b0);
        for (int i = 1; i < 8; i++) cycle(1'b1, DATA_W'(i), 1'b0);
        repeat (8) cycle(1'b0, '0, 1'b1);
        check_eq("cks_frame1", 32'(bus.frame_checksum), 32'h001B);
        repeat (8) cycle(1'b1, 16'h0001, 1'b0);
        repeat (8) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check_eq("cks_frame2", 32'(bus.frame_checksum), 32'h0008);
`endif
        cycle(1'b0, '0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/off_chip_img_stream_feeder.md
# off_chip_img_stream_feeder

Upstream source stage for `dummy_sobel_app_in_cgra_1_opt`. It takes pixels from an off-chip/DMA write stream into a show-ahead FIFO and serves them to the app's `off_chip_img_img_update_0_read_en` / `off_chip_img_img_update_0_read` port. It tracks raster position, flags frame completion and records underflow. This replaces the random-data driver with a deterministic, back-pressured pixel source for power and functional runs.

## Interface
Parameters:
- `DATA_W`, 16, pixel width.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `IMG_W`, 64, pixels per row.
- `IMG_H`, 64, rows per frame.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-high reset, despite the name (1 = reset).
- `in_valid`  in  1  upstream pixel valid.
- `in_data`  in  DATA_W  upstream pixel.
- `in_ready`  out  1  FIFO can accept a pixel this cycle.
- `off_chip_img_img_update_0_read_en`  in  1  app consumes the head pixel this cycle.
- `off_chip_img_img_update_0_read`  out  DATA_W  head pixel; the app port is an unpacked `[0:0]` array, and this drives element 0.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `col`  out  $clog2(IMG_W)  column of the head pixel.
- `row`  out  $clog2(IMG_H)  row of the head pixel.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is popped.
- `underflow`  out  1  sticky; set when a read is attempted on an empty FIFO.
- `frame_checksum`  out  DATA_W  present only with `FEEDER_CHECKSUM_EN`.

## Operation
- **Push:** `in_valid && in_ready`. Writes `in_data` at `wr_ptr`, then increments `wr_ptr` modulo DEPTH.
- **in_ready:** combinational, equal to `level != DEPTH`. When full, a push is refused even if a pop occurs in the same cycle.
- **Read data:** `read = mem[rd_ptr]` when `level > 0`, otherwise 0. The FIFO is show-ahead: the head pixel is valid in the same cycle `read_en` is sampled.
- **Pop:** `read_en && level > 0`. Increments `rd_ptr` modulo DEPTH.
- **Empty read:** `read_en && level == 0` sets `underflow`. No pointer, raster or checksum change. There is no bypass from `in_data`, even if a push occurs in the same cycle.
- **level update:** +1 on push only, −1 on pop only, unchanged on push and pop together.
- **Raster counters** advance only on a pop:
  - `col` increments.
  - At `col == IMG_W-1`, `col` wraps to 0 and `row` increments.
  - At `row == IMG_H-1 && col == IMG_W-1`, both wrap to 0 and `frame_done` is asserted for the following cycle.
- **Cleared only by reset:** `underflow`, the pointers, `level`, `row`, `col`.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `read` = 0.
  - `level`, `col`, `row` = 0.
  - `frame_done`, `underflow` = 0.
  - `frame_checksum` = 0.
- Push latency: a pixel pushed at edge N is at the head and visible on `read` in cycle N+1 if the FIFO was empty.
- Pop latency: a pop at edge N exposes the next entry, or 0 if the FIFO is now empty, in cycle N+1.
- Throughput is 1 push and 1 pop per cycle in steady state.
- `frame_done` is registered and high for exactly one cycle, the cycle after the edge that popped the last pixel.
- `underflow` rises in the cycle after the offending edge.
- Reset mid-frame discards all FIFO contents and counters in one cycle. `in_ready` is 1 in the cycle after reset deasserts.
- Pointer wrap at DEPTH-1 → 0 must not disturb `level`.

## Configuration
- Macro: `FEEDER_CHECKSUM_EN`.
- **Defined:**
  - A DATA_W accumulator adds each popped pixel modulo 2^DATA_W.
  - On the frame-end pop, `frame_checksum` is loaded with accumulator + final pixel, and the accumulator clears to 0.
  - `frame_checksum` holds its value until the next frame end.
- **Undefined:** the `frame_checksum` port and accumulator are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst_n=1` for 2 cycles → all outputs at their reset values; `in_ready=1`, `level=0`.
- **Fill then drain:**
  - Push 16 pixels 0x0001..0x0010 with `read_en=0` → `level=16`, `in_ready=0`; a 17th push is refused.
  - Then `read_en=1` for 16 cycles → `read` shows 0x0001..0x0010 in order, and `level` returns to 0.
- **Underflow:** `read_en=1` while empty, with a simultaneous push of 0xABCD → `underflow=1` next cycle, `level=1`, `read=0xABCD`, `col` unchanged.
- **Frame wrap** (IMG_W=4, IMG_H=2): stream 8 pixels through → `col` reads 0,1,2,3,0,1,2,3 and `row` goes 0→1→0. `frame_done` pulses exactly once, the cycle after the 8th pop.
- **Concurrent push/pop at wrap:**
  - Keep `level=8` with simultaneous push and pop across 40 cycles → `level` stays 8 and data order is preserved across the `rd_ptr`/`wr_ptr` wrap.
  - Reset mid-stream → `level=0`, `read=0`.
- **Checksum** (`FEEDER_CHECKSUM_EN`, IMG_W=4, IMG_H=2): pixels 0xFFFF,1,2,3,4,5,6,7 → `frame_checksum=0x001B` after `frame_done`. A second frame of all 0x0001 → `0x0008`.
